// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO. Results are computed when the operation is
// accepted, parked in shadow registers, and committed after a fixed busy window.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic [31:0]        hi_r, lo_r;
    logic [31:0]        res_hi_r, res_lo_r;
    logic               res_we_r;

    logic               idle_start_s, launch_s, done_s;
    logic [31:0]        res_hi_s, res_lo_s;
    logic               res_we_s;
    logic [63:0]        prod_s;
    logic [31:0]        divisor_s, abs_a_s, abs_b_s, uq_s, ur_s;

    assign idle_start_s = (state_r == ST_IDLE) && start;
    assign launch_s     = idle_start_s && (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
    assign done_s       = (state_r == ST_BUSY) && (cnt_r == CNT_W'(1));

    // Result datapath; a zero divisor is replaced by 1 so the divider never sees 0.
    always_comb begin
        res_hi_s  = 32'd0;
        res_lo_s  = 32'd0;
        res_we_s  = 1'b0;
        prod_s    = 64'd0;
        divisor_s = (b == 32'd0) ? 32'd1 : b;
        abs_a_s   = a[31] ? (32'd0 - a) : a;
        abs_b_s   = divisor_s[31] ? (32'd0 - divisor_s) : divisor_s;
        uq_s      = 32'd0;
        ur_s      = 32'd0;
        case (mdu_op)
            OP_MULT: begin
                prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                res_we_s = 1'b1;
            end
            OP_MULTU: begin
                prod_s   = {32'd0, a} * {32'd0, b};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                res_we_s = 1'b1;
            end
            OP_DIV: begin
                uq_s     = abs_a_s / abs_b_s;
                ur_s     = abs_a_s % abs_b_s;
                res_lo_s = (a[31] ^ divisor_s[31]) ? (32'd0 - uq_s) : uq_s;
                res_hi_s = a[31] ? (32'd0 - ur_s) : ur_s;
                res_we_s = (b != 32'd0);
            end
            OP_DIVU: begin
                uq_s     = a / divisor_s;
                ur_s     = a % divisor_s;
                res_lo_s = uq_s;
                res_hi_s = ur_s;
                res_we_s = (b != 32'd0);
            end
            default: begin
                res_we_s = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) state_s = ST_BUSY;
                else          state_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (done_s) state_s = ST_IDLE;
                else        state_s = ST_BUSY;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_BUSY);
        end
    end

    // Busy-window counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (launch_s) begin
            cnt_r <= ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU)) ?
                     CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if ((state_r == ST_BUSY) && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Shadow result, captured only when an operation is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_hi_r <= 32'd0;
            res_lo_r <= 32'd0;
            res_we_r <= 1'b0;
        end else if (launch_s) begin
            res_hi_r <= res_hi_s;
            res_lo_r <= res_lo_s;
            res_we_r <= res_we_s;
        end
    end

    // Committed HI/LO: completion commit or mthi/mtlo, never both in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (done_s) begin
            if (res_we_r) begin
                hi_r <= res_hi_r;
                lo_r <= res_lo_r;
            end
        end else if (idle_start_s && (mdu_op == OP_MTHI)) begin
            hi_r <= a;
        end else if (idle_start_s && (mdu_op == OP_MTLO)) begin
            lo_r <= a;
        end
    end

    // Read port for mfhi/mflo.
    always_comb begin
        if (rd_sel) rdata = hi_r;
        else        rdata = lo_r;
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
endmodule
